// File: rtl/clock_pkg.sv
// Shared definitions for the set-time sequencer and its BCD increment helper.
// Contents:
//   state_t            sequencer states
//   FIELD_*            edit_field codes driven to the display
//   HR_MAX / MS_MAX    highest legal BCD value of the hour and min/sec pairs
//   field_code()       edit_field code for a given state
//   is_set_state()     true in the three field-edit states
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HR   = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  function automatic logic [1:0] field_code(input state_t st);
    logic [1:0] code;
    case (st)
      ST_SET_HR:  code = FIELD_HR;
      ST_SET_MIN: code = FIELD_MIN;
      ST_SET_SEC: code = FIELD_SEC;
      default:    code = FIELD_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_set_state(input state_t st);
    logic res;
    case (st)
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: res = 1'b1;
      default:                           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/bcd2_inc.sv
// Combinational increment of a two-digit BCD value with wrap to 00.
// Ports:
//   val      in  8  BCD pair {d1,d0}
//   max_val  in  8  largest legal value of the pair (BCD), wraps to 00 after it
//   inc_val  out 8  incremented pair
// Any illegal input (a digit above 9, or a value above max_val) yields 00.
module bcd2_inc
  import clock_pkg::*;
(
  input  logic [7:0] val,
  input  logic [7:0] max_val,
  output logic [7:0] inc_val
);

  // Increment with wrap; plain magnitude compare is valid once both digits are <= 9.
  always_comb begin
    inc_val = 8'h00;
    if ((val[3:0] > 4'd9) || (val[7:4] > 4'd9) || (val >= max_val)) begin
      inc_val = 8'h00;
    end else if (val[3:0] == 4'd9) begin
      inc_val = {val[7:4] + 4'd1, 4'd0};
    end else begin
      inc_val = {val[7:4], val[3:0] + 4'd1};
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Seconds-tick generator and operator set-time sequencer for the HH:MM:SS chain.
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   btn_mode          pulse: enter set / next field / commit
//   btn_inc           pulse: increment the selected field
//   btn_cancel        pulse: abandon the edit without loading
//   cur_hms   [23:0]  live time {h1,h0,m1,m0,s1,s0}
//   tick_en           1 Hz one-cycle enable to the seconds counter
//   load              one-cycle load strobe to all three counters
//   ld_hms    [23:0]  shadow time, valid while load is high
//   edit_field [1:0]  selected field (0 none, 1 hr, 2 min, 3 sec)
//   blink             display enable for the selected field
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_DIV   = 50_000_000,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_cancel,
  input  logic [23:0] cur_hms,
  output logic        tick_en,
  output logic        load,
  output logic [23:0] ld_hms,
  output logic [1:0]  edit_field,
  output logic        blink
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  state_t          state_r;
  state_t          next_state_s;
  logic [PW-1:0]   presc_r;
  logic [PW-1:0]   presc_d;
  logic [BW-1:0]   blink_cnt_r;
  logic [BW-1:0]   blink_cnt_d;
  logic            blink_r;
  logic            blink_d;
  logic            tick_r;
  logic            tick_d;
  logic            load_r;
  logic            load_d;
  logic [1:0]      field_r;
  logic [1:0]      field_d;
  logic [23:0]     shadow_r;
  logic            capture_s;
  logic            inc_accept_s;
  logic [7:0]      sel_val_s;
  logic [7:0]      sel_max_s;
  logic [7:0]      inc_val_s;

  // Mode wins over inc, cancel wins over both, so inc only counts when alone.
  assign capture_s    = (state_r == ST_RUN) && btn_mode;
  assign inc_accept_s = is_set_state(state_r) && btn_inc && !btn_mode && !btn_cancel;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode with cancel > mode priority.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (btn_mode) next_state_s = ST_SET_HR;
        else          next_state_s = ST_RUN;
      end
      ST_SET_HR: begin
        if (btn_cancel)    next_state_s = ST_RUN;
        else if (btn_mode) next_state_s = ST_SET_MIN;
        else               next_state_s = ST_SET_HR;
      end
      ST_SET_MIN: begin
        if (btn_cancel)    next_state_s = ST_RUN;
        else if (btn_mode) next_state_s = ST_SET_SEC;
        else               next_state_s = ST_SET_MIN;
      end
      ST_SET_SEC: begin
        if (btn_cancel)    next_state_s = ST_RUN;
        else if (btn_mode) next_state_s = ST_COMMIT;
        else               next_state_s = ST_SET_SEC;
      end
      ST_COMMIT: next_state_s = ST_RUN;
      default:   next_state_s = ST_RUN;
    endcase
  end

  // Output decode: values the registered outputs take in the next state.
  // The prescaler only runs while staying in RUN, so a tick can never land in a
  // set state and the count restarts from 0 on every return to RUN.
  always_comb begin
    tick_d  = 1'b0;
    presc_d = PW'(0);
    if ((state_r == ST_RUN) && (next_state_s == ST_RUN)) begin
      if (presc_r == PW'(CLK_DIV - 1)) begin
        presc_d = PW'(0);
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_r + PW'(1);
        tick_d  = 1'b0;
      end
    end else begin
      presc_d = PW'(0);
      tick_d  = 1'b0;
    end
    load_d  = (next_state_s == ST_COMMIT);
    field_d = field_code(next_state_s);
  end

  // Blink generator: restarts visible on field entry and on every accepted increment.
  always_comb begin
    blink_cnt_d = blink_cnt_r;
    blink_d     = blink_r;
    if (!is_set_state(next_state_s)) begin
      blink_cnt_d = BW'(0);
      blink_d     = 1'b1;
    end else if ((next_state_s != state_r) || inc_accept_s) begin
      blink_cnt_d = BW'(0);
      blink_d     = 1'b1;
    end else if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = BW'(0);
      blink_d     = ~blink_r;
    end else begin
      blink_cnt_d = blink_cnt_r + BW'(1);
      blink_d     = blink_r;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_r     <= PW'(0);
      blink_cnt_r <= BW'(0);
      blink_r     <= 1'b1;
      tick_r      <= 1'b0;
      load_r      <= 1'b0;
      field_r     <= FIELD_NONE;
    end else begin
      presc_r     <= presc_d;
      blink_cnt_r <= blink_cnt_d;
      blink_r     <= blink_d;
      tick_r      <= tick_d;
      load_r      <= load_d;
      field_r     <= field_d;
    end
  end

  // Select the pair being edited for the shared incrementer.
  always_comb begin
    sel_val_s = 8'h00;
    sel_max_s = MS_MAX;
    case (state_r)
      ST_SET_HR: begin
        sel_val_s = shadow_r[23:16];
        sel_max_s = HR_MAX;
      end
      ST_SET_MIN: begin
        sel_val_s = shadow_r[15:8];
        sel_max_s = MS_MAX;
      end
      ST_SET_SEC: begin
        sel_val_s = shadow_r[7:0];
        sel_max_s = MS_MAX;
      end
      default: begin
        sel_val_s = 8'h00;
        sel_max_s = MS_MAX;
      end
    endcase
  end

  bcd2_inc u_bcd2_inc (
    .val     (sel_val_s),
    .max_val (sel_max_s),
    .inc_val (inc_val_s)
  );

  // Shadow time: captured on entry to edit, then updated field by field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_r <= 24'h000000;
    end else if (capture_s) begin
      shadow_r <= cur_hms;
    end else if (inc_accept_s) begin
      case (state_r)
        ST_SET_HR:  shadow_r[23:16] <= inc_val_s;
        ST_SET_MIN: shadow_r[15:8]  <= inc_val_s;
        ST_SET_SEC: shadow_r[7:0]   <= inc_val_s;
        default:    shadow_r        <= shadow_r;
      endcase
    end else begin
      shadow_r <= shadow_r;
    end
  end

  assign tick_en    = tick_r;
  assign load       = load_r;
  assign ld_hms     = shadow_r;
  assign edit_field = field_r;
  assign blink      = blink_r;

endmodule
